alu_muldiv_seq: RTL and testbench
=================================

ALU_MULDIV_SEQ -- requirements
Module: alu_muldiv_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, async active-low reset.
REQ-002 start input 1 SHALL mean "operation request", sampled on a clk edge only while busy=0.
REQ-003 func3 input 3 SHALL select the RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-004 op_a input 32 SHALL be the multiplicand or dividend; op_b input 32 SHALL be the multiplier or divisor. Both SHALL be captured at the start edge.
REQ-005 flush input 1 SHALL request a synchronous abort of any in-flight operation.
REQ-006 busy output 1 SHALL be high from the edge after start is accepted until the edge that asserts done.
REQ-007 done output 1 SHALL be a single-cycle completion pulse.
REQ-008 result output 32 SHALL carry the operation result, valid while done=1 and held until the next accepted start.
REQ-009 illegal output 1 SHALL be a single-cycle pulse coincident with done for an op that is not compiled in.

Function
REQ-010 The FSM SHALL have the states IDLE, MUL, DIV, FIXUP and DONE; the reset state SHALL be IDLE.
REQ-011 IDLE SHALL transition as follows: start=1 and flush=0 goes to MUL if func3[2]=0, else to DIV; operands, func3 and the operand signs are latched.
REQ-012 The operand signs SHALL be applied per op: MUL/MULH/DIV/REM both signed; MULHSU a signed, b unsigned; MULHU/DIVU/REMU unsigned. The iteration SHALL operate on magnitudes.
REQ-013 MUL state SHALL perform a shift-add of one multiplier bit per cycle into a 64-bit accumulator, 32 cycles, counted by a 6-bit iteration counter.
REQ-014 DIV state SHALL perform a restoring divide producing one quotient bit per cycle using a 33-bit subtract of the partial remainder, 32 cycles.
REQ-015 FIXUP SHALL, in one cycle, negate the product or quotient when the operand signs differ, negate the remainder when the dividend is negative, and select the result: MUL selects product[31:0]; MULH/MULHSU/MULHU select product[63:32]; DIV/DIVU select the quotient; REM/REMU select the remainder.
REQ-016 DONE SHALL assert done for 1 cycle, drive result, and return to IDLE on the next edge.
REQ-017 The normal latency SHALL be: start sampled at edge N, done high in the cycle following edge N+34, and the next start accepted at edge N+35.
REQ-018 A divide by zero SHALL skip the iteration, go directly from IDLE to DONE, and return quotient 0xFFFFFFFF and remainder op_a; done SHALL be high after edge N+1.
REQ-019 Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF, DIV/REM) SHALL take the same fast path and return quotient 0x80000000 and remainder 0.
REQ-020 A start received while busy=1 SHALL be ignored, with no queuing.
REQ-021 flush=1 in any state SHALL force IDLE at the next edge; no done SHALL be produced; result SHALL keep its previous value.
REQ-022 When flush and start are both high in IDLE, flush SHALL win and start SHALL be dropped.
REQ-023 Operand inputs SHALL be don't-care after the start edge; changes SHALL have no effect on the in-flight op.

Reset
REQ-024 rst_n=0 SHALL immediately force: state=IDLE, busy=0, done=0, illegal=0, result=0x00000000, counter=0, accumulators=0.
REQ-025 Reset asserted mid-operation SHALL abandon the op with no done pulse; the first start accepted SHALL be the one sampled at the first rising edge after rst_n deassertion.

Configuration
REQ-026 The divide path SHALL be controlled by the macro ALU_MULDIV_DIV_EN. When defined, all 8 ops SHALL be implemented and illegal SHALL stay 0.
REQ-027 When ALU_MULDIV_DIV_EN is undefined, no DIV/divider logic SHALL be synthesized; func3[2]=1 SHALL go IDLE->DONE with result=0x00000000, done=1 and illegal=1 after edge N+1; multiply behaviour SHALL be unchanged.

Verification
REQ-028 MUL 0x00000007 x 0xFFFFFFFD (-3) -> result 0xFFFFFFEB, done exactly 34 clocks after the start edge, busy high 34 cycles.
REQ-029 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
REQ-030 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-031 DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5 with done 1 clock after start; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 with fast done.
REQ-032 MUL start, flush at iteration 10 -> busy low next edge, no done, result unchanged; start pulses during busy -> no effect, single done.
REQ-033 rst_n low at iteration 20 of DIV -> all outputs zero immediately, no done; with ALU_MULDIV_DIV_EN undefined, DIV -> illegal=1, done=1, result 0 one clock after start.

Source files
------------

// File: rtl/alu_muldiv_seq.sv
// Sequential RV32M multiply/divide unit: 32-cycle shift-add multiply, 32-cycle restoring divide.
// Define ALU_MULDIV_DIV_EN to build the divider; otherwise divide ops complete at once with illegal=1.
module alu_muldiv_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [2:0]  func3,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic        flush,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic        illegal
);

   typedef enum logic [2:0] {IDLE, MUL, DIV, FIXUP, DONE} state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [63:0] acc_q, acc_d;
   logic [31:0] mcand_q, mcand_d;
   logic [2:0]  func_q, func_d;
   logic        neg_res_q, neg_res_d;
   logic        neg_rem_q, neg_rem_d;
   logic        ill_q, ill_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        illegal_q, illegal_d;
   logic [31:0] result_q, result_d;

   logic        a_signed, b_signed, a_neg, b_neg;
   logic [31:0] a_mag, b_mag;
   logic [32:0] mul_sum;
   logic [63:0] prod_fix;
   logic [31:0] quot_fix, rem_fix;

   // Iteration runs on magnitudes; the signs are re-applied once in FIXUP.
   always_comb begin
      a_signed = (func3 == 3'b000) || (func3 == 3'b001) || (func3 == 3'b010) ||
                 (func3 == 3'b100) || (func3 == 3'b110);
      b_signed = (func3 == 3'b000) || (func3 == 3'b001) ||
                 (func3 == 3'b100) || (func3 == 3'b110);
      a_neg    = a_signed && op_a[31];
      b_neg    = b_signed && op_b[31];
      a_mag    = a_neg ? (32'd0 - op_a) : op_a;
      b_mag    = b_neg ? (32'd0 - op_b) : op_b;
      mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);
      prod_fix = neg_res_q ? (64'd0 - acc_q) : acc_q;
      quot_fix = neg_res_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
      rem_fix  = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
   end

`ifdef ALU_MULDIV_DIV_EN
   logic [32:0] rem_sh;
   logic [33:0] diff;
   logic        borrow;

   always_comb begin
      rem_sh = acc_q[63:31];
      diff   = {1'b0, rem_sh} - {2'b00, mcand_q};
      // diff[32] can only be set when the subtract went negative.
      borrow = diff[33] | diff[32];
   end
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      func_d    = func_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      ill_d     = ill_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      illegal_d = 1'b0;
      result_d  = result_q;

      case (state_q)
         IDLE: begin
            if (start && !flush) begin
               busy_d    = 1'b1;
               cnt_d     = 6'd0;
               neg_res_d = a_neg ^ b_neg;
               neg_rem_d = a_neg;
               ill_d     = 1'b0;
               if (!func3[2]) begin
                  state_d = MUL;
                  func_d  = func3;
                  mcand_d = a_mag;
                  acc_d   = {32'd0, b_mag};
               end else begin
`ifdef ALU_MULDIV_DIV_EN
                  func_d = func3;
                  if (op_b == 32'd0) begin
                     state_d = DONE;
                     acc_d   = {32'd0, func3[1] ? op_a : 32'hFFFF_FFFF};
                  end else if (!func3[0] && op_a == 32'h8000_0000 && op_b == 32'hFFFF_FFFF) begin
                     state_d = DONE;
                     acc_d   = {32'd0, func3[1] ? 32'd0 : 32'h8000_0000};
                  end else begin
                     state_d = DIV;
                     mcand_d = b_mag;
                     acc_d   = {32'd0, a_mag};
                  end
`else
                  state_d = DONE;
                  acc_d   = 64'd0;
                  ill_d   = 1'b1;
`endif
               end
            end
         end
         MUL: begin
            acc_d = {mul_sum, acc_q[31:1]};
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
               state_d = FIXUP;
               cnt_d   = 6'd0;
            end
         end
`ifdef ALU_MULDIV_DIV_EN
         DIV: begin
            acc_d = borrow ? {rem_sh[31:0], acc_q[30:0], 1'b0}
                           : {diff[31:0], acc_q[30:0], 1'b1};
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
               state_d = FIXUP;
               cnt_d   = 6'd0;
            end
         end
`endif
         FIXUP: begin
            state_d = DONE;
            if (func_q[2])
               acc_d = {32'd0, func_q[1] ? rem_fix : quot_fix};
            else
               acc_d = {32'd0, (func_q[1:0] == 2'b00) ? prod_fix[31:0] : prod_fix[63:32]};
         end
         DONE: begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            illegal_d = ill_q;
            result_d  = acc_q[31:0];
         end
         default: state_d = IDLE;
      endcase

      if (flush) begin
         state_d   = IDLE;
         cnt_d     = 6'd0;
         busy_d    = 1'b0;
         done_d    = 1'b0;
         illegal_d = 1'b0;
         result_d  = result_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= 6'd0;
         acc_q     <= 64'd0;
         mcand_q   <= 32'd0;
         func_q    <= 3'd0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         ill_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
         result_q  <= 32'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         func_q    <= func_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         ill_q     <= ill_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         illegal_q <= illegal_d;
         result_q  <= result_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign illegal = illegal_q;
   assign result  = result_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed-vector bench for alu_muldiv_seq; divide expectations follow ALU_MULDIV_DIV_EN.
module tb_alu_muldiv_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [2:0]  func3;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        illegal;

`ifdef ALU_MULDIV_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   int chk_cnt  = 0;
   int pass_cnt = 0;
   logic [31:0] last_res;

   always #5 clk = ~clk;

   alu_muldiv_seq dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .func3   (func3),
      .op_a    (op_a),
      .op_b    (op_b),
      .flush   (flush),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .illegal (illegal)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp)
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      else
         pass_cnt++;
   endtask

   // Issue one op, wait for done (bounded), check result, latency, busy length and illegal.
   task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input int exp_lat, input logic exp_ill);
      int lat = 0;
      int busy_n = 0;
      bit seen = 0;
      logic [31:0] res = 32'd0;
      logic ill = 1'b0;
      start = 1'b1;
      func3 = f;
      op_a  = a;
      op_b  = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      func3 = 3'($urandom);
      op_a  = $urandom;
      op_b  = $urandom;
      for (int i = 0; i < 100 && !seen; i++) begin
         if (busy) busy_n++;
         @(posedge clk);
         #1;
         lat++;
         if (done) begin
            seen = 1;
            res  = result;
            ill  = illegal;
         end
      end
      check({tag, " done seen"}, 32'(seen), 32'd1);
      check({tag, " result"}, res, exp_res);
      check({tag, " latency"}, lat, exp_lat);
      check({tag, " busy cycles"}, busy_n, exp_lat);
      check({tag, " illegal"}, 32'(ill), 32'(exp_ill));
      @(posedge clk);
      #1;
      check({tag, " done one cycle"}, 32'(done), 32'd0);
      $display("op %-8s f=%b a=%h b=%h -> res=%h ill=%b lat=%0d", tag, f, a, b, res, ill, lat);
      last_res = exp_res;
   endtask

   initial begin
      int done_n;
      logic [31:0] cap;
      rst_n = 1'b0;
      start = 1'b0;
      flush = 1'b0;
      func3 = 3'd0;
      op_a  = 32'd0;
      op_b  = 32'd0;
      last_res = 32'd0;
      #1;
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset illegal", 32'(illegal), 32'd0);
      check("reset result", result, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      do_op("MUL", 3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1'b0);
      do_op("MUL2", 3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 34, 1'b0);
      do_op("MULHU", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 1'b0);
      do_op("MULH", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34, 1'b0);
      do_op("MULHSU", 3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 34, 1'b0);
      do_op("DIV", 3'b100, 32'hFFFF_FFF9, 32'd2, DIV_EN ? 32'hFFFF_FFFD : 32'd0,
            DIV_EN ? 34 : 1, !DIV_EN);
      do_op("REM", 3'b110, 32'hFFFF_FFF9, 32'd2, DIV_EN ? 32'hFFFF_FFFF : 32'd0,
            DIV_EN ? 34 : 1, !DIV_EN);
      do_op("DIVU", 3'b101, 32'd100, 32'd7, DIV_EN ? 32'd14 : 32'd0, DIV_EN ? 34 : 1, !DIV_EN);
      do_op("REMU", 3'b111, 32'd100, 32'd7, DIV_EN ? 32'd2 : 32'd0, DIV_EN ? 34 : 1, !DIV_EN);
      do_op("DIVU0", 3'b101, 32'd5, 32'd0, DIV_EN ? 32'hFFFF_FFFF : 32'd0, 1, !DIV_EN);
      do_op("REM0", 3'b110, 32'd5, 32'd0, DIV_EN ? 32'd5 : 32'd0, 1, !DIV_EN);
      do_op("DIVOVF", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, DIV_EN ? 32'h8000_0000 : 32'd0,
            1, !DIV_EN);
      do_op("REMOVF", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, !DIV_EN);
      do_op("MULREF", 3'b000, 32'd6, 32'd9, 32'd54, 34, 1'b0);

      // Flush mid-multiply: no done, result keeps its previous value.
      start = 1'b1; func3 = 3'b000; op_a = 32'd3; op_b = 32'd5;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("flush busy", 32'(busy), 32'd0);
      check("flush done", 32'(done), 32'd0);
      done_n = 0;
      repeat (40) begin @(posedge clk); #1; if (done) done_n++; end
      check("flush no done", done_n, 0);
      check("flush result held", result, last_res);
      $display("op flush    mid-MUL -> busy=%b result=%h", busy, result);

      // Flush and start together in IDLE: start dropped.
      start = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; flush = 1'b0;
      check("flush+start busy", 32'(busy), 32'd0);
      $display("op flush+start -> busy=%b", busy);

      // Starts during busy are ignored.
      start = 1'b1; func3 = 3'b000; op_a = 32'h0000_0007; op_b = 32'hFFFF_FFFD;
      @(posedge clk);
      #1;
      start = 1'b0;
      done_n = 0;
      cap = 32'd0;
      for (int i = 0; i < 60; i++) begin
         if (i == 5 || i == 15 || i == 25) begin
            start = 1'b1; func3 = 3'b011; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
         if (done) begin
            done_n++;
            cap = result;
         end
      end
      start = 1'b0;
      check("busy-start single done", done_n, 1);
      check("busy-start result", cap, 32'hFFFF_FFEB);
      $display("op busy-start -> dones=%0d res=%h", done_n, cap);

      // Reset asserted mid-operation.
      start = 1'b1; func3 = DIV_EN ? 3'b100 : 3'b000; op_a = 32'd100; op_b = 32'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (20) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      check("midrst busy", 32'(busy), 32'd0);
      check("midrst done", 32'(done), 32'd0);
      check("midrst illegal", 32'(illegal), 32'd0);
      check("midrst result", result, 32'd0);
      $display("op reset mid-op -> busy=%b done=%b result=%h", busy, done, result);
      @(negedge clk);
      rst_n = 1'b1;
      done_n = 0;
      repeat (40) begin @(posedge clk); #1; if (done) done_n++; end
      check("midrst no done", done_n, 0);
      do_op("MULHU2", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
